// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for a 5-stage RV32I pipeline. Resolves dmem wait
// states, EX-stage redirects and load-use hazards by fixed priority, tracks
// dmem wait length with a timeout FSM and keeps saturating perf counters.
//
// Handshake: there is no valid/ready pair on this block. mem_req_i/mem_ready_i
// form a request/complete pair: an access completes in any cycle where both
// are high; a cycle with mem_req_i=1 and mem_ready_i=0 is a wait cycle that
// freezes everything upstream of MEM and bubbles MEM/WB.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  output logic                  pc_en_o,
  output logic                  ifid_en_o,
  output logic                  idex_en_o,
  output logic                  exmem_en_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  memwb_flush_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic                  mem_err_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  // Wait count value at which one more wait cycle is a timeout.
  localparam logic [7:0] LP_LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_mem_err;

  logic w_wait;
  logic w_load_use;
  logic w_redirect_evt;
  logic w_stall_evt;
  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
  logic w_ifid_flush, w_idex_flush, w_memwb_flush;

  assign w_wait = mem_req_i & ~mem_ready_i;

  assign w_load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  // State and wait counter register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state logic for the dmem wait/timeout FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_wait) begin
          if (MEM_TIMEOUT == 1) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt    = ST_MEM_WAIT;
            w_wait_cnt_nxt = 8'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          // Completion in the would-be timeout cycle still counts as success.
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = 8'd0;
        end else if (w_wait && (r_wait_cnt == LP_LAST_WAIT)) begin
          w_state_nxt = ST_ERR;
        end else if (r_wait_cnt != 8'hFF) begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Priority resolution of enables and flushes: ERR, wait, redirect, load-use.
  always_comb begin
    w_pc_en        = 1'b1;
    w_ifid_en      = 1'b1;
    w_idex_en      = 1'b1;
    w_exmem_en     = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_memwb_flush  = 1'b0;
    w_redirect_evt = 1'b0;
    if (r_state == ST_ERR) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_en    = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_memwb_flush = 1'b1;
    end else if (w_wait) begin
      // EX stays frozen, so a pending redirect or load-use is re-presented later.
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_en    = 1'b0;
      w_memwb_flush = 1'b1;
    end else if (ex_redirect_i) begin
      // The ID instruction is squashed, so no load-use stall is needed.
      w_ifid_flush   = 1'b1;
      w_idex_flush   = 1'b1;
      w_redirect_evt = 1'b1;
    end else if (w_load_use) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  assign w_stall_evt = (r_state != ST_ERR) && !w_pc_en;

  // Reset forces the whole pipeline to hold and bubble, independent of the clock.
  assign pc_en_o       = reset_ni & w_pc_en;
  assign ifid_en_o     = reset_ni & w_ifid_en;
  assign idex_en_o     = reset_ni & w_idex_en;
  assign exmem_en_o    = reset_ni & w_exmem_en;
  assign ifid_flush_o  = ~reset_ni | w_ifid_flush;
  assign idex_flush_o  = ~reset_ni | w_idex_flush;
  assign memwb_flush_o = ~reset_ni | w_memwb_flush;

  // Saturating stall and redirect-flush perf counters.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_redirect_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // Sticky timeout flag, raised one cycle after the FSM lands in ERR.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_mem_err <= 1'b0;
    end else if (r_state == ST_ERR) begin
      r_mem_err <= 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
  assign mem_err_o   = r_mem_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed scenarios plus randomized traffic against a cycle-level reference
// model of the priority rules, timeout and saturating counters.
module tb_pipeline_hazard_ctrl;

  localparam int RW   = 5;
  localparam int CW   = 6;
  localparam int TO   = 16;
  localparam int MAXC = (1 << CW) - 1;

  // Output vector order: pc, ifid, idex, exmem, ifid_fl, idex_fl, memwb_fl
  localparam logic [6:0] V_HOLD   = 7'b0000111;
  localparam logic [6:0] V_WAIT   = 7'b0000001;
  localparam logic [6:0] V_REDIR  = 7'b1111110;
  localparam logic [6:0] V_LU     = 7'b0011010;
  localparam logic [6:0] V_NORMAL = 7'b1111000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_u1, id_u2, ex_mr, ex_redir, mem_req, mem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, memwb_fl, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0] dbg_state;
  logic [6:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, memwb_fl};

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs1_i(id_u1), .id_uses_rs2_i(id_u2),
    .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mr), .ex_redirect_i(ex_redir),
    .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en), .exmem_en_o(exmem_en),
    .ifid_flush_o(ifid_fl), .idex_flush_o(idex_fl), .memwb_flush_o(memwb_fl),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_err_o(mem_err),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int m_stall, m_flush, m_run, m_err_age;
  bit m_err;
  logic [6:0] e_outs;
  int e_class; // 0 reset, 1 err, 2 wait, 3 redirect, 4 load-use, 5 normal

  function automatic void model_comb();
    bit lu;
    lu = ex_mr && (ex_rd != 0) && ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd));
    if (!rst_n)                       begin e_class = 0; e_outs = V_HOLD;   end
    else if (m_err)                   begin e_class = 1; e_outs = V_HOLD;   end
    else if (mem_req && !mem_ready)   begin e_class = 2; e_outs = V_WAIT;   end
    else if (ex_redir)                begin e_class = 3; e_outs = V_REDIR;  end
    else if (lu)                      begin e_class = 4; e_outs = V_LU;     end
    else                              begin e_class = 5; e_outs = V_NORMAL; end
  endfunction

  function automatic void model_reset();
    m_stall = 0; m_flush = 0; m_run = 0; m_err = 0; m_err_age = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_u1 = 0; id_u2 = 0; ex_rd = 0;
    ex_mr = 0; ex_redir = 0; mem_req = 0; mem_ready = 1;
  endtask

  // One clock: advance the model across the rising edge, return at the falling edge.
  task automatic tick();
    model_comb();
    @(posedge clk);
    if (rst_n) begin
      if (e_class != 1 && !e_outs[6] && m_stall < MAXC) m_stall++;
      if (e_class == 3 && m_flush < MAXC) m_flush++;
      if (m_err) m_err_age++;
      else if (e_class == 2) begin
        m_run++;
        if (m_run == TO) begin m_err = 1; m_err_age = 0; end
      end else m_run = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    id_rs1 = 5; id_u1 = 1; ex_rd = 5; ex_mr = 1; ex_redir = 1; mem_req = 1; mem_ready = 0;
    #1;
    checks++; if (outs !== V_HOLD) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, V_HOLD); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", mem_err); end
    do_reset();
    #1;
    checks++; if (outs !== V_NORMAL) begin failures++; $display("FAIL reset_release got=%b exp=%b", outs, V_NORMAL); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mr = 1; ex_rd = 5; id_rs1 = 5; id_u1 = 1; #1;
    checks++; if (outs !== V_LU) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", outs, V_LU); end
    tick();
    // The load has moved on; EX now holds the bubble.
    ex_mr = 0; #1;
    checks++; if (stall_cnt !== 1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (outs !== V_NORMAL) begin failures++; $display("FAIL lu_single_bubble got=%b exp=%b", outs, V_NORMAL); end
    ex_mr = 1; ex_rd = 9; id_rs1 = 1; id_rs2 = 9; id_u1 = 1; id_u2 = 1; #1;
    checks++; if (outs !== V_LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", outs, V_LU); end
    id_u2 = 0; #1;
    checks++; if (outs !== V_NORMAL) begin failures++; $display("FAIL lu_unused_src got=%b exp=%b", outs, V_NORMAL); end
    ex_rd = 0; id_rs1 = 0; id_u1 = 1; #1;
    checks++; if (outs !== V_NORMAL) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", outs, V_NORMAL); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    ex_mr = 1; ex_rd = 5; id_rs1 = 5; id_u1 = 1; ex_redir = 1; #1;
    checks++; if (outs !== V_REDIR) begin failures++; $display("FAIL redir_over_lu got=%b exp=%b", outs, V_REDIR); end
    tick();
    set_idle(); #1;
    checks++; if (flush_cnt !== 1 || stall_cnt !== 0) begin failures++; $display("FAIL redir_cnts got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs !== V_WAIT) begin failures++; $display("FAIL wait_c%0d got=%b exp=%b", i, outs, V_WAIT); end
      tick();
    end
    mem_ready = 1; #1;
    checks++; if (outs !== V_NORMAL) begin failures++; $display("FAIL wait_done got=%b exp=%b", outs, V_NORMAL); end
    tick();
    set_idle(); #1;
    checks++; if (stall_cnt !== 3) begin failures++; $display("FAIL wait_stall_cnt got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_deferred_redirect();
    do_reset();
    mem_req = 1; mem_ready = 0; ex_redir = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (outs !== V_WAIT) begin failures++; $display("FAIL defer_c%0d got=%b exp=%b", i, outs, V_WAIT); end
      tick();
    end
    #1;
    checks++; if (flush_cnt !== 0) begin failures++; $display("FAIL defer_no_flush got=%0d exp=0", flush_cnt); end
    mem_ready = 1; #1;
    checks++; if (outs !== V_REDIR) begin failures++; $display("FAIL defer_release got=%b exp=%b", outs, V_REDIR); end
    tick();
    set_idle(); #1;
    checks++; if (flush_cnt !== 1 || stall_cnt !== 2) begin failures++; $display("FAIL defer_cnts got=%0d/%0d exp=1/2", flush_cnt, stall_cnt); end
  endtask

  task automatic test_timeout();
    // Ready arriving in the would-be timeout cycle avoids the error.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (TO - 1) tick();
    mem_ready = 1; #1;
    checks++; if (outs !== V_NORMAL) begin failures++; $display("FAIL to_ready_wins got=%b exp=%b", outs, V_NORMAL); end
    tick();
    set_idle(); tick(); #1;
    checks++; if (mem_err !== 1'b0 || outs !== V_NORMAL) begin failures++; $display("FAIL to_no_err got=%b/%b exp=0/%b", mem_err, outs, V_NORMAL); end
    // Ready never rises: ERR after TO wait cycles.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      checks++; if (outs !== V_WAIT) begin failures++; $display("FAIL to_wait_c%0d got=%b exp=%b", i, outs, V_WAIT); end
      tick();
    end
    #1;
    checks++; if (outs !== V_HOLD) begin failures++; $display("FAIL to_err_entry got=%b exp=%b", outs, V_HOLD); end
    mem_ready = 1; ex_redir = 1; #1;
    checks++; if (outs !== V_HOLD) begin failures++; $display("FAIL to_err_ignores got=%b exp=%b", outs, V_HOLD); end
    tick();
    #1;
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL to_mem_err got=%b exp=1", mem_err); end
    checks++; if (stall_cnt !== TO || flush_cnt !== 0) begin failures++; $display("FAIL to_cnts got=%0d/%0d exp=%0d/0", stall_cnt, flush_cnt, TO); end
    set_idle(); repeat (3) tick(); #1;
    checks++; if (mem_err !== 1'b1 || outs !== V_HOLD) begin failures++; $display("FAIL to_sticky got=%b/%b exp=1/%b", mem_err, outs, V_HOLD); end
    do_reset(); #1;
    checks++; if (mem_err !== 1'b0 || outs !== V_NORMAL) begin failures++; $display("FAIL to_reset_clears got=%b/%b exp=0/%b", mem_err, outs, V_NORMAL); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ex_mr = 1; ex_rd = 3; id_rs2 = 3; id_u2 = 1;
    tick();
    set_idle(); mem_req = 1; mem_ready = 0;
    tick(); tick(); #1;
    checks++; if (stall_cnt !== 3) begin failures++; $display("FAIL mid_pre_stall got=%0d exp=3", stall_cnt); end
    @(posedge clk); #3;
    rst_n = 0; model_reset(); #1;
    checks++; if (outs !== V_HOLD) begin failures++; $display("FAIL mid_async_outs got=%b exp=%b", outs, V_HOLD); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL mid_async_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    @(negedge clk);
    set_idle(); rst_n = 1; #1;
    checks++; if (outs !== V_NORMAL) begin failures++; $display("FAIL mid_release got=%b exp=%b", outs, V_NORMAL); end
    tick(); #1;
    checks++; if (stall_cnt !== 0 || outs !== V_NORMAL) begin failures++; $display("FAIL mid_run got=%0d/%b exp=0/%b", stall_cnt, outs, V_NORMAL); end
  endtask

  task automatic test_random();
    int waits;
    waits = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      id_rs1 = RW'($urandom_range(0, 3));
      id_rs2 = RW'($urandom_range(0, 3));
      ex_rd  = RW'($urandom_range(0, 3));
      id_u1  = 1'($urandom_range(0, 1));
      id_u2  = 1'($urandom_range(0, 1));
      ex_mr  = 1'($urandom_range(0, 1));
      ex_redir = ($urandom_range(0, 5) == 0);
      mem_req  = ($urandom_range(0, 3) == 0) || (waits != 0);
      mem_ready = !mem_req || (waits >= 4) || ($urandom_range(0, 1) == 1);
      waits = (mem_req && !mem_ready) ? waits + 1 : 0;
      #1;
      model_comb();
      checks++; if (outs !== e_outs) begin failures++; $display("FAIL rand_outs n=%0d got=%b exp=%b", n, outs, e_outs); end
      checks++; if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
        failures++; $display("FAIL rand_cnts n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      if (!m_err || m_err_age >= 1) begin
        checks++; if (mem_err !== m_err) begin failures++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, mem_err, m_err); end
      end
      tick();
    end
    set_idle(); #1;
    checks++; if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
      failures++; $display("FAIL rand_final got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence and report ----------------
  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_deferred_redirect();
    test_reset_mid_wait();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
